// File: rtl/spart_ctrl.sv
// spart_ctrl: bus-side controller for the serial port.
//   Owns the baud divisor and produces the 16x oversample tick (baud_en).
//   Captures received bytes into a holding register with ready/overrun
//   status. Hands transmit bytes to the transmitter under a TBR handshake.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   iocs, iorw, ioaddr    processor I/O bus select / direction / address
//   bus_wdata, bus_rdata  bus write data in, combinational read data out
//   baud_en               one-cycle oversample tick
//   rx_enable             receiver enable (control bit 0)
//   rx_data, rx_rda       receiver byte and data-available level
//   rx_ack                one-cycle pulse clearing the receiver's rda
//   tx_data, tx_load      byte and load strobe to the transmitter
//   tx_tbr                transmitter buffer ready
module spart_ctrl #(
   parameter logic [15:0] DIV_RESET = 16'd162
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic       baud_en,
   output logic       rx_enable,
   input  logic [7:0] rx_data,
   input  logic       rx_rda,
   output logic       rx_ack,
   output logic [7:0] tx_data,
   output logic       tx_load,
   input  logic       tx_tbr
);

   logic [15:0] divisor_q;
   logic [15:0] divisor_d;
   logic [15:0] count_q;
   logic [7:0]  hold_q;
   logic        rdaQ_q;
   logic        overrun_q;
   logic        txDrop_q;
   logic        rxEnable_q;
   logic        rxAck_q;
   logic        rdaPrev_q;
   logic [7:0]  txData_q;
   logic        txLoad_q;

   logic wrEn;
   logic rdEn;
   logic divWr;
   logic ctrlWr;
   logic holdRd;
   logic txWr;
   logic rxRise;

   assign wrEn   = iocs & ~iorw;
   assign rdEn   = iocs & iorw;
   assign txWr   = wrEn && (ioaddr == 2'b00);
   assign ctrlWr = wrEn && (ioaddr == 2'b01);
   assign divWr  = wrEn && ioaddr[1];
   assign holdRd = rdEn && (ioaddr == 2'b00);
   // The edge register tracks rx_rda even while disabled, so a level that is
   // already high when the receiver gets enabled never counts as a new byte.
   assign rxRise = rx_rda & ~rdaPrev_q & rxEnable_q;

   // Merge a divisor byte write into the full 16-bit value; the counter is
   // reloaded with this merged value so the new rate starts cleanly.
   always_comb begin
      divisor_d = divisor_q;
      if (divWr) begin
         if (ioaddr[0]) divisor_d = {bus_wdata, divisor_q[7:0]};
         else           divisor_d = {divisor_q[15:8], bus_wdata};
      end
   end

   // A divisor write in the same cycle as a terminal count wins: the tick is
   // swallowed and the counter restarts from the new divisor.
   assign baud_en = (count_q == 16'd0) && !divWr;

   always_comb begin
      bus_rdata = 8'h00;
      if (iocs) begin
         case (ioaddr)
            2'b00:   bus_rdata = hold_q;
            2'b01:   bus_rdata = {4'b0000, txDrop_q, overrun_q, tx_tbr, rdaQ_q};
            2'b10:   bus_rdata = divisor_q[7:0];
            default: bus_rdata = divisor_q[15:8];
         endcase
      end
   end

   // Baud generator: down counter that reloads from the divisor at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         divisor_q <= DIV_RESET;
         count_q   <= DIV_RESET;
      end else begin
         divisor_q <= divisor_d;
         if (divWr)                  count_q <= divisor_d;
         else if (count_q == 16'd0)  count_q <= divisor_q;
         else                        count_q <= count_q - 16'd1;
      end
   end

   // Receive capture. On overrun the unread byte is kept and the new one is
   // lost, but the receiver is still acknowledged so it can continue. A read
   // of the hold register on the capture edge frees the slot, so the new byte
   // goes in without an overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxEnable_q <= 1'b0;
         hold_q     <= 8'h00;
         rdaQ_q     <= 1'b0;
         overrun_q  <= 1'b0;
         rxAck_q    <= 1'b0;
         rdaPrev_q  <= 1'b0;
      end else begin
         rdaPrev_q <= rx_rda;
         rxAck_q   <= rxRise;
         if (ctrlWr) begin
            rxEnable_q <= bus_wdata[0];
            if (bus_wdata[1]) overrun_q <= 1'b0;
         end
         if (rxRise) begin
            if (rdaQ_q && !holdRd) begin
               overrun_q <= 1'b1;
            end else begin
               hold_q <= rx_data;
               rdaQ_q <= 1'b1;
            end
         end else if (holdRd) begin
            rdaQ_q <= 1'b0;
         end
      end
   end

   // Transmit handoff: accept the byte only when the transmitter is ready,
   // otherwise flag the drop so software can notice it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txData_q <= 8'h00;
         txLoad_q <= 1'b0;
         txDrop_q <= 1'b0;
      end else begin
         txLoad_q <= 1'b0;
         if (ctrlWr && bus_wdata[2]) txDrop_q <= 1'b0;
         if (txWr) begin
            if (tx_tbr) begin
               txData_q <= bus_wdata;
               txLoad_q <= 1'b1;
            end else begin
               txDrop_q <= 1'b1;
            end
         end
      end
   end

   assign rx_enable = rxEnable_q;
   assign rx_ack    = rxAck_q;
   assign tx_data   = txData_q;
   assign tx_load   = txLoad_q;

endmodule

// File: tb/tb_spart_ctrl.sv
// tb_spart_ctrl: self-checking bench for spart_ctrl. Transmit bytes and
// received bytes are pushed to scoreboard queues when driven and popped when
// the DUT presents them (tx_load strobe, read of the hold register).
module tb_spart_ctrl;

   logic       clk;
   logic       rst;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;
   logic       baud_en;
   logic       rx_enable;
   logic [7:0] rx_data;
   logic       rx_rda;
   logic       rx_ack;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_tbr;

   int checkCount = 0;
   int errorCount = 0;
   int txLoadCount = 0;
   int rxAckCount = 0;
   logic [7:0] txQ[$];
   logic [7:0] rxQ[$];

   spart_ctrl #(.DIV_RESET(16'd162)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .baud_en(baud_en),
      .rx_enable(rx_enable), .rx_data(rx_data), .rx_rda(rx_rda),
      .rx_ack(rx_ack), .tx_data(tx_data), .tx_load(tx_load), .tx_tbr(tx_tbr)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Transmit side of the scoreboard: every tx_load must match the oldest
   // byte written while the transmitter was ready.
   always @(negedge clk) begin
      if (rst && tx_load) begin
         txLoadCount++;
         if (txQ.size() == 0) checkOutput("txUnexpected", 16'd1, 16'd0);
         else                 checkOutput("txData", {8'h00, tx_data}, {8'h00, txQ.pop_front()});
      end
      if (rst && rx_ack) rxAckCount++;
   end

   task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = addr; bus_wdata = data;
      @(negedge clk);
      iocs = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] addr, output logic [7:0] data);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = addr;
      #1 data = bus_rdata;
      @(negedge clk);
      iocs = 1'b0;
   endtask

   task automatic readExpect(input string tag, input logic [1:0] addr,
                             input logic [7:0] expected);
      logic [7:0] d;
      busRead(addr, d);
      checkOutput(tag, {8'h00, d}, {8'h00, expected});
   endtask

   // Read of the hold register, compared against the receive scoreboard.
   task automatic readHold(input string tag);
      logic [7:0] d;
      busRead(2'b00, d);
      if (rxQ.size() == 0) checkOutput({tag, "Empty"}, 16'd1, 16'd0);
      else                 checkOutput(tag, {8'h00, d}, {8'h00, rxQ.pop_front()});
   endtask

   // Measure the spacing between two consecutive baud ticks in cycles.
   task automatic measureBaud(input string tag, input int expected);
      int c;
      c = 0;
      while (!baud_en && c < 400) begin @(negedge clk); c++; end
      c = 0;
      do begin @(negedge clk); c++; end while (!baud_en && c < 400);
      checkOutput(tag, c[15:0], expected[15:0]);
   endtask

   // Present one byte from the receiver as a rising rx_rda edge.
   task automatic sendRx(input logic [7:0] data, input bit expectCapture);
      @(negedge clk);
      rx_data = data; rx_rda = 1'b1;
      if (expectCapture) rxQ.push_back(data);
      @(negedge clk);
      rx_rda = 1'b0;
   endtask

   initial begin
      int ackBefore;
      int loadBefore;
      rst = 1'b0; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; bus_wdata = 8'h00;
      rx_data = 8'h00; rx_rda = 1'b0; tx_tbr = 1'b0;
      repeat (3) @(negedge clk);
      iocs = 1'b1; ioaddr = 2'b01;
      #1 checkOutput("resetStatus", {8'h00, bus_rdata}, 16'h0000);
      checkOutput("resetOutputs", {5'd0, rx_ack, tx_load, rx_enable, tx_data},
                  16'h0000);
      iocs = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("firstCycle", {14'd0, baud_en, rx_ack}, 16'd0);

      measureBaud("baudReset", 163);
      readExpect("statusIdle", 2'b01, 8'h00);

      applyStimulus(2'b10, 8'h03);
      applyStimulus(2'b11, 8'h00);
      measureBaud("baudDiv3a", 4);
      measureBaud("baudDiv3b", 4);
      readExpect("divLo", 2'b10, 8'h03);
      readExpect("divHi", 2'b11, 8'h00);

      applyStimulus(2'b01, 8'h01);
      checkOutput("rxEnable", {15'd0, rx_enable}, 16'd1);
      @(negedge clk);
      rx_data = 8'hA5; rx_rda = 1'b1; rxQ.push_back(8'hA5);
      @(negedge clk);
      checkOutput("rxAckOn", {15'd0, rx_ack}, 16'd1);
      @(negedge clk);
      checkOutput("rxAckOff", {15'd0, rx_ack}, 16'd0);
      rx_rda = 1'b0;
      readExpect("statusRda", 2'b01, 8'h01);
      readHold("holdA5");
      readExpect("statusCleared", 2'b01, 8'h00);

      sendRx(8'hA5, 1'b1);
      sendRx(8'h3C, 1'b0);
      checkOutput("rxAckOverrun", {15'd0, rx_ack}, 16'd1);
      readExpect("statusOverrun", 2'b01, 8'h05);
      readHold("holdKeepsOld");
      applyStimulus(2'b01, 8'h03);
      readExpect("overrunCleared", 2'b01, 8'h00);
      checkOutput("rxEnableKept", {15'd0, rx_enable}, 16'd1);

      sendRx(8'h11, 1'b1);
      @(negedge clk);
      rx_data = 8'h22; rx_rda = 1'b1;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
      #1 checkOutput("simulReadOld", {8'h00, bus_rdata}, {8'h00, rxQ.pop_front()});
      rxQ.push_back(8'h22);
      @(negedge clk);
      iocs = 1'b0; rx_rda = 1'b0;
      readExpect("simulStatus", 2'b01, 8'h01);
      readHold("simulNewByte");

      tx_tbr = 1'b1;
      txQ.push_back(8'h55);
      applyStimulus(2'b00, 8'h55);
      repeat (3) @(negedge clk);
      checkOutput("txLoadOnce", txLoadCount[15:0], 16'd1);
      tx_tbr = 1'b0;
      applyStimulus(2'b00, 8'h66);
      repeat (3) @(negedge clk);
      checkOutput("txNoLoad", txLoadCount[15:0], 16'd1);
      checkOutput("txDataKept", {8'h00, tx_data}, 16'h0055);
      readExpect("statusDrop", 2'b01, 8'h08);
      applyStimulus(2'b01, 8'h05);
      readExpect("dropCleared", 2'b01, 8'h00);

      @(negedge clk);
      rx_data = 8'h77; rx_rda = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1 checkOutput("midReset", {5'd0, rx_ack, tx_load, rx_enable, tx_data}, 16'h0000);
      checkOutput("midResetBaud", {15'd0, baud_en}, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      ackBefore = rxAckCount;
      loadBefore = txLoadCount;
      repeat (3) @(negedge clk);
      readExpect("noStaleRda", 2'b01, 8'h00);
      applyStimulus(2'b01, 8'h01);
      repeat (3) @(negedge clk);
      readExpect("heldHighIgnored", 2'b01, 8'h00);
      checkOutput("noAckAfterReset", rxAckCount[15:0], ackBefore[15:0]);
      checkOutput("noLoadAfterReset", txLoadCount[15:0], loadBefore[15:0]);
      @(negedge clk);
      rx_rda = 1'b0;
      sendRx(8'h9A, 1'b1);
      readHold("holdAfterReset");

      checkOutput("txQueueEmpty", txQ.size(), 16'd0);
      checkOutput("rxQueueEmpty", rxQ.size(), 16'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Absolute time limit so a stuck run still ends with a report.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] time limit reached");
   end

endmodule

// File: doc/spart_ctrl.md
Name: spart_ctrl

Overview:
- Bus-side controller for the serial port: owns the baud-rate divisor and generates the 16x oversample enable consumed by the receiver and transmitter.
- Captures received bytes into a holding register with ready/overrun status, and gates receive enable.
- Hands transmit bytes to the transmitter under a TBR handshake.
- Sits between the processor I/O bus (iocs/iorw/ioaddr) and the receiver/transmitter datapaths.

Parameters:
- DIV_RESET, 16'd162: divisor loaded at reset; baud_en period = divisor+1 clk cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- iocs  in  1  bus chip select
- iorw  in  1  1 = read, 0 = write (valid when iocs=1)
- ioaddr  in  2  register address
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data, combinational from ioaddr
- baud_en  out  1  one-cycle oversample tick to receiver/transmitter
- rx_enable  out  1  receiver enable (control bit 0)
- rx_data  in  8  receiver data byte
- rx_rda  in  1  receiver data-available level
- rx_ack  out  1  one-cycle pulse clearing receiver's rda
- tx_data  out  8  byte to transmitter
- tx_load  out  1  one-cycle load strobe to transmitter
- tx_tbr  in  1  transmitter buffer ready

Behaviour:
- Reset (rst=0, async): divisor=DIV_RESET, baud counter=DIV_RESET, baud_en=0, rx_enable=0, hold=0, rda_q=0, overrun=0, tx_drop=0, rx_ack=0, tx_load=0, tx_data=0, rx_rda edge register=0. Reset mid-frame discards all state; no pulses in the first cycle after release.
- Register map, reads have no side effects unless stated:
  - 00 R: hold; clears rda_q on the same edge. W: transmit byte.
  - 01 R: {4'b0, tx_drop, overrun, tx_tbr, rda_q}. W: bit0 -> rx_enable; bit1=1 clears overrun; bit2=1 clears tx_drop.
  - 10 R/W: divisor[7:0].
  - 11 R/W: divisor[15:8].
- bus_rdata = 8'h00 when iocs=0.
- Baud generator:
  - 16-bit down counter. When count==0: baud_en=1 for that cycle, counter reloads divisor; otherwise decrement.
  - Divisor 0 gives baud_en every cycle.
  - Any divisor byte write reloads the counter with the new full divisor on the next edge and suppresses baud_en in that cycle.
  - baud_en runs regardless of rx_enable.
- Receive capture:
  - Rising edge of rx_rda (registered previous value 0, current 1) captures rx_data into hold on that edge and sets rda_q.
  - rx_ack pulses the following cycle.
  - If rda_q is already 1 and no same-cycle read of 00: overrun=1 (sticky), hold keeps the OLD byte, rx_ack still pulses.
  - Simultaneous capture and read of 00: read returns the old hold; new byte is captured; rda_q stays 1; no overrun.
  - Capture is ignored when rx_enable=0 (no rda_q, no rx_ack).
- Transmit:
  - Write to 00 with tx_tbr=1: tx_data<=bus_wdata; tx_load=1 on the next cycle only.
  - Write to 00 with tx_tbr=0: data dropped, tx_drop=1 (sticky), no tx_load.
- Bus:
  - Write side effects occur on the clk edge where iocs=1 and iorw=0.
  - Back-to-back accesses are allowed every cycle.
- Latency:
  - rx_rda rising to rda_q visible in status: 1 cycle.
  - Bus write to tx_load: 1 cycle.

Test Plan:
- Reset then idle 400 cycles -> baud_en pulses every 163 cycles; status reads 8'h00 with tx_tbr=0.
- Write divisor lo=8'h03, hi=8'h00 -> counter restarts; baud_en every 4 cycles; read 10/11 returns 03/00.
- Control=01; drive rx_data=8'hA5 and raise rx_rda -> rda_q=1 next cycle, rx_ack one-cycle pulse; read 00 returns A5; status bit0 then 0.
- Second byte 8'h3C arrives with rda_q=1 -> overrun=1, read 00 returns A5. Write control 8'h03 -> overrun cleared, rx_enable kept.
- tx_tbr=1, write 00 with 8'h55 -> tx_data=55 and single tx_load pulse. tx_tbr=0, write 8'h66 -> no tx_load, tx_data stays 55, status bit3=1.
- Assert rst low mid-capture (rx_rda high) -> all outputs 0 immediately. On release with rx_rda still high, no capture until rx_rda falls and rises again.
